// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared router definitions: default byte width, header length
//            field position, stored-entry layout (tag + data) and a clog2
//            helper. Used by the packet FIFO, router FSM and synchroniser.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package router_pkg;

    localparam int RTR_DATA_W  = 8;  // default data byte width
    localparam int RTR_LEN_LSB = 2;  // header[LEN_LSB-1:0] is destination address
    localparam int RTR_TAG_W   = 1;  // lfd tag stored alongside each byte

    // One stored FIFO entry at the default byte width.
    typedef struct packed {
        logic                  tag;
        logic [RTR_DATA_W-1:0] data;
    } router_entry_t;

    // Ceiling log2 for parameter arithmetic.
    function automatic int rtr_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo_pkt_if.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo_pkt_if
// Purpose  : Write/read handshake and status bundle of the packet FIFO.
//   master : write side (write_enb, lfd_state, data_in) and read side
//            (read_enb) requests; observes all status/data outputs.
//   slave  : the FIFO; drives data_out, data_valid, hdr_out, pkt_last,
//            pkt_busy, full, empty, almost_full, count.
// Revision : 1.0 - initial release
// ============================================================================
interface router_fifo_pkt_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              hdr_out;
    logic              pkt_last;
    logic              pkt_busy;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CNT_W-1:0]  count;

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, data_valid, hdr_out, pkt_last, pkt_busy,
               full, empty, almost_full, count
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, data_valid, hdr_out, pkt_last, pkt_busy,
               full, empty, almost_full, count
    );

endinterface
`default_nettype wire

// File: rtl/router_pkt_tracker.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tracker
// Purpose  : Read-side packet boundary tracker. A header read loads the
//            remaining-byte counter with len+1 (payload + parity); each
//            following untagged read decrements it. Outputs are registered
//            so they line up with the FIFO's registered data_out.
// Ports    : clock, reset, soft_reset   - clock and synchronous clears
//            i_rd_accept                - a FIFO read is taken this cycle
//            i_tag, i_len               - tag bit / length field of that entry
//            o_pkt_last                 - data_out is the packet's parity byte
//            o_pkt_busy                 - bytes of the packet still to come
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_tracker #(
    parameter int DATA_W  = 8,
    parameter int LEN_LSB = 2
) (
    input  wire logic                      clock,
    input  wire logic                      reset,
    input  wire logic                      soft_reset,
    input  wire logic                      i_rd_accept,
    input  wire logic                      i_tag,
    input  wire logic [DATA_W-LEN_LSB-1:0] i_len,
    output logic                           o_pkt_last,
    output logic                           o_pkt_busy
);
    localparam int REM_W = DATA_W - LEN_LSB + 1;

    logic [REM_W-1:0] r_remaining;

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            r_remaining <= '0;
            o_pkt_last  <= 1'b0;
            o_pkt_busy  <= 1'b0;
        end else if (i_rd_accept) begin
            if (i_tag) begin
                // A header always starts a new packet, even mid-packet.
                r_remaining <= REM_W'(i_len) + REM_W'(1);
                o_pkt_last  <= 1'b0;
                o_pkt_busy  <= 1'b1;
            end else if (r_remaining != '0) begin
                r_remaining <= r_remaining - REM_W'(1);
                o_pkt_last  <= (r_remaining == REM_W'(1));
                o_pkt_busy  <= (r_remaining != REM_W'(1));
            end else begin
                // Stray byte outside any packet: no boundary information.
                o_pkt_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo_pkt
// Purpose  : Per-destination packet FIFO. Stores {lfd tag, data} entries,
//            registered 1-cycle read, occupancy/flag decode, soft-reset
//            flush and read-side packet boundary tracking.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            soft_reset        - synchronous flush from the router FSM
//            bus (slave)       - write/read handshake, data and status
// Revision : 1.0 - initial release
// ============================================================================
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter int DATA_W    = RTR_DATA_W,
    parameter int DEPTH     = 16,
    parameter int LEN_LSB   = RTR_LEN_LSB,
    parameter int AF_MARGIN = 2
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          soft_reset,
    router_fifo_pkt_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;   // extra MSB is the wrap bit

    logic [DATA_W:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;

    logic [PW-1:0]   w_count;
    logic [PW-1:0]   w_free;
    logic            w_full;
    logic            w_empty;
    logic            w_clear;
    logic            w_wr_accept;
    logic            w_rd_accept;
    logic [DATA_W:0] w_rd_entry;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_free      = PW'(DEPTH) - w_count;
    assign w_full      = (w_count == PW'(DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_clear     = reset || soft_reset;

    // No pass-through: a full FIFO refuses writes even if a read frees a slot.
    assign w_wr_accept = bus.write_enb && !w_full  && !w_clear;
    assign w_rd_accept = bus.read_enb  && !w_empty && !w_clear;
    assign w_rd_entry  = r_mem[r_rd_ptr[AW-1:0]];

    assign bus.count       = w_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = (w_free <= PW'(AF_MARGIN));

    // Storage is not cleared on reset; pointers define what is valid.
    always_ff @(posedge clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            bus.data_out   <= '0;
            bus.hdr_out    <= 1'b0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= w_rd_accept;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr     <= r_rd_ptr + PW'(1);
                bus.data_out <= w_rd_entry[DATA_W-1:0];
                bus.hdr_out  <= w_rd_entry[DATA_W];
            end
        end
    end

    router_pkt_tracker #(
        .DATA_W  (DATA_W),
        .LEN_LSB (LEN_LSB)
    ) u_tracker (
        .clock       (clock),
        .reset       (reset),
        .soft_reset  (soft_reset),
        .i_rd_accept (w_rd_accept),
        .i_tag       (w_rd_entry[DATA_W]),
        .i_len       (w_rd_entry[DATA_W-1:LEN_LSB]),
        .o_pkt_last  (bus.pkt_last),
        .o_pkt_busy  (bus.pkt_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_router_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_fifo_pkt
// Purpose  : Self-checking bench for router_fifo_pkt (DATA_W=8, DEPTH=16).
//            A reference FIFO model feeds an expected-output scoreboard;
//            directed scenario tasks add targeted checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_fifo_pkt;
    import router_pkg::*;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int LEN_LSB   = 2;
    localparam int AF_MARGIN = 2;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              h;
        logic              l;
        logic              b;
    } exp_t;

    logic clk;
    logic rst;
    logic srst;

    int n_vec;
    int n_err;

    router_entry_t mdl[$];   // reference FIFO contents
    exp_t          sb[$];    // expected read results, oldest first
    int            m_rem;
    exp_t          held;     // value data_out/hdr/last/busy should show

    router_fifo_pkt_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    router_fifo_pkt #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .LEN_LSB   (LEN_LSB),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .soft_reset (srst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model, check every output #1 later.
    task automatic drive_cycle(input logic we, input logic lfd, input logic [7:0] din,
                               input logic re, input logic sr, input logic rs);
        logic          wr_ok;
        logic          rd_ok;
        router_entry_t e;
        exp_t          x;
        int            sz;
        bus.write_enb = we;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        bus.read_enb  = re;
        srst          = sr;
        rst           = rs;
        sz    = mdl.size();
        wr_ok = we && (sz < DEPTH) && !sr && !rs;
        rd_ok = re && (sz > 0) && !sr && !rs;
        if (sr || rs) begin
            mdl.delete();
            sb.delete();
            m_rem  = 0;
            held.d = '0; held.h = 1'b0; held.l = 1'b0; held.b = 1'b0;
        end else begin
            if (rd_ok) begin
                e = mdl.pop_front();
                if (e.tag) begin
                    m_rem = int'(e.data[7:LEN_LSB]) + 1;
                    x.l   = 1'b0;
                end else if (m_rem != 0) begin
                    x.l   = (m_rem == 1);
                    m_rem = m_rem - 1;
                end else begin
                    x.l   = 1'b0;
                end
                x.d = e.data; x.h = e.tag; x.b = (m_rem != 0);
                sb.push_back(x);
            end
            if (wr_ok) begin
                e.tag = lfd; e.data = din;
                mdl.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        sz = mdl.size();
        n_vec++;
        if (bus.data_valid !== rd_ok) begin
            n_err++;
            $display("FAIL data_valid: got %b want %b", bus.data_valid, rd_ok);
        end
        if (bus.data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: got data_valid=1 want no read pending");
            end else begin
                held = sb.pop_front();
            end
        end
        n_vec++;
        if ({bus.data_out, bus.hdr_out, bus.pkt_last, bus.pkt_busy} !== {held.d, held.h, held.l, held.b}) begin
            n_err++;
            $display("FAIL read_data: got d=%h h=%b l=%b b=%b want d=%h h=%b l=%b b=%b",
                     bus.data_out, bus.hdr_out, bus.pkt_last, bus.pkt_busy,
                     held.d, held.h, held.l, held.b);
        end
        n_vec++;
        if ({bus.count, bus.full, bus.empty, bus.almost_full} !==
            {5'(sz), sz == DEPTH, sz == 0, (DEPTH - sz) <= AF_MARGIN}) begin
            n_err++;
            $display("FAIL flags: got cnt=%0d f=%b e=%b af=%b want cnt=%0d", bus.count,
                     bus.full, bus.empty, bus.almost_full, sz);
        end
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic lfd, input logic [7:0] d);
        drive_cycle(1'b1, lfd, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic write_pkt5();
        wr(1'b1, 8'h0D); wr(1'b0, 8'hA1); wr(1'b0, 8'hA2);
        wr(1'b0, 8'hA3); wr(1'b0, 8'h5C);
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        n_vec++;
        if ({bus.empty, bus.full, bus.count, bus.data_out, bus.data_valid} !== {1'b1, 1'b0, 5'd0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got e=%b f=%b cnt=%0d d=%h v=%b want e=1 f=0 cnt=0 d=00 v=0",
                     bus.empty, bus.full, bus.count, bus.data_out, bus.data_valid);
        end
    endtask

    task automatic test_packet();
        logic [7:0] want [5];
        want[0] = 8'h0D; want[1] = 8'hA1; want[2] = 8'hA2; want[3] = 8'hA3; want[4] = 8'h5C;
        do_reset();
        write_pkt5();
        for (int i = 0; i < 5; i++) begin
            rd();
            n_vec++;
            if ({bus.data_out, bus.hdr_out, bus.pkt_last, bus.pkt_busy} !==
                {want[i], i == 0, i == 4, i != 4}) begin
                n_err++;
                $display("FAIL pkt_byte%0d: got d=%h h=%b l=%b b=%b want d=%h", i,
                         bus.data_out, bus.hdr_out, bus.pkt_last, bus.pkt_busy, want[i]);
            end
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr(1'b0, 8'(8'h40 + i));
            n_vec++;
            if ({bus.almost_full, bus.full} !== {i >= 13, i >= 15}) begin
                n_err++;
                $display("FAIL fill_w%0d: got af=%b f=%b want af=%b f=%b", i + 1,
                         bus.almost_full, bus.full, i >= 13, i >= 15);
            end
        end
        n_vec++;
        if (bus.count !== 5'd16) begin
            n_err++;
            $display("FAIL fill_count: got %0d want 16", bus.count);
        end
        for (int i = 0; i < 16; i++) begin
            rd();
            n_vec++;
            if (bus.data_out !== 8'(8'h40 + i)) begin
                n_err++;
                $display("FAIL drain_%0d: got %h want %h", i, bus.data_out, 8'(8'h40 + i));
            end
        end
        rd();
        n_vec++;
        if ({bus.empty, bus.data_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL read_empty: got e=%b v=%b want e=1 v=0", bus.empty, bus.data_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) wr(1'b0, 8'(i));
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (bus.count !== 5'd12) begin
                n_err++;
                $display("FAIL b2b_count%0d: got %0d want 12", i, bus.count);
            end
        end
    endtask

    task automatic test_soft_reset();
        do_reset();
        write_pkt5();
        rd(); rd();
        drive_cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({bus.count, bus.empty, bus.pkt_busy, bus.data_out} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL soft_reset: got cnt=%0d e=%b b=%b d=%h want cnt=0 e=1 b=0 d=00",
                     bus.count, bus.empty, bus.pkt_busy, bus.data_out);
        end
        idle();
        n_vec++;
        if (bus.count !== 5'd0) begin
            n_err++;
            $display("FAIL soft_reset_wr: got cnt=%0d want 0", bus.count);
        end
    endtask

    task automatic test_reset_reload();
        do_reset();
        write_pkt5();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if ({bus.data_valid, bus.empty, bus.count} !== {1'b0, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL both_reset: got v=%b e=%b cnt=%0d want v=0 e=1 cnt=0",
                     bus.data_valid, bus.empty, bus.count);
        end
        // len=2 header, then stray untagged byte after the packet, then len=0.
        wr(1'b1, 8'h09); wr(1'b0, 8'h11); wr(1'b0, 8'h22); wr(1'b0, 8'h33);
        wr(1'b0, 8'h77); wr(1'b1, 8'h02); wr(1'b0, 8'h99);
        for (int i = 0; i < 7; i++) rd();
        n_vec++;
        if ({bus.data_out, bus.pkt_last, bus.pkt_busy} !== {8'h99, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL len0_parity: got d=%h l=%b b=%b want d=99 l=1 b=0",
                     bus.data_out, bus.pkt_last, bus.pkt_busy);
        end
        // Header arriving mid-packet reloads the counter.
        wr(1'b1, 8'h0C); wr(1'b0, 8'h01); wr(1'b1, 8'h04); wr(1'b0, 8'h02); wr(1'b0, 8'h03);
        for (int i = 0; i < 5; i++) rd();
        n_vec++;
        if ({bus.pkt_last, bus.pkt_busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reload: got l=%b b=%b want l=1 b=0", bus.pkt_last, bus.pkt_busy);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_rem = 0;
        held.d = '0; held.h = 1'b0; held.l = 1'b0; held.b = 1'b0;
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = 1'b0;
        rst  = 1'b1;
        srst = 1'b0;
        test_reset();
        test_packet();
        test_fill_drain();
        test_back_to_back();
        test_soft_reset();
        test_reset_reload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
